// File: rtl/cordic_sincos_arbiter.sv
// Round-robin multi-channel front-end for the shared sin/cos CORDIC core.
// Ports: clk/rst; req_* client requests; rsp_* held responses; core_* core handshake.
module cordic_sincos_arbiter #(
    parameter int W       = 32,
    parameter int N_CH    = 4,
    parameter int TMO_CYC = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       req_valid,
    output logic [N_CH-1:0]       req_ready,
    input  logic [2*N_CH-1:0]     req_op,
    input  logic [W*N_CH-1:0]     req_angle,
    input  logic [2*N_CH-1:0]     req_region,
    output logic [N_CH-1:0]       rsp_valid,
    input  logic [N_CH-1:0]       rsp_ack,
    output logic [2*W*N_CH-1:0]   rsp_data,
    output logic [4*N_CH-1:0]     rsp_flags,
    output logic                  core_beg,
    output logic                  core_op,
    output logic [W-1:0]          core_data,
    output logic [1:0]            core_region,
    input  logic                  core_ready,
    input  logic [W-1:0]          core_result,
    input  logic                  core_ovf,
    input  logic                  core_unf,
    output logic                  core_ack
);

    localparam int CW = $clog2(N_CH);
    localparam int TW = $clog2(TMO_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_ACK, S_ABORT, S_DONE
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_ptr;
    logic [CW-1:0]       r_ch;
    logic [1:0]          r_op;
    logic [W-1:0]        r_angle;
    logic [1:0]          r_region;
    logic                r_pass;
    logic [TW-1:0]       r_tmr;
    logic [W-1:0]        r_res0;
    logic [W-1:0]        r_res1;
    logic                r_ill;
    logic                r_tmo;
    logic                r_unf;
    logic                r_ovf;
    logic                r_core_beg;
    logic                r_core_op;
    logic                r_core_ack;
    logic [N_CH-1:0]     r_rsp_valid;
    logic [2*W*N_CH-1:0] r_rsp_data;
    logic [4*N_CH-1:0]   r_rsp_flags;

    logic [N_CH-1:0]     w_elig;
    logic                w_found;
    logic [CW-1:0]       w_gnt;
    logic [1:0]          w_gop;
    logic [W-1:0]        w_gang;
    logic [1:0]          w_greg;
    logic                w_xfer;
    logic [TW-1:0]       w_tmr_nxt;
    logic                w_tmo_hit;

    assign w_elig = req_valid & ~r_rsp_valid;
    assign w_xfer = (r_state == S_IDLE) && w_found;
    assign w_tmr_nxt = r_tmr + 1'b1;
    assign w_tmo_hit = (w_tmr_nxt == TW'(TMO_CYC));

    // Scan offsets from highest to lowest so the channel nearest
    // to r_ptr is the last (winning) assignment.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_gnt   = '0;
        w_gop   = '0;
        w_gang  = '0;
        w_greg  = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = (int'(r_ptr) + k) % N_CH;
            if (w_elig[idx]) begin
                w_found = 1'b1;
                w_gnt   = CW'(idx);
                w_gop   = req_op[2*idx +: 2];
                w_gang  = req_angle[W*idx +: W];
                w_greg  = req_region[2*idx +: 2];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_xfer) begin
            req_ready[w_gnt] = 1'b1;
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_flags   = r_rsp_flags;
    assign core_beg    = r_core_beg;
    assign core_op     = r_core_op;
    assign core_ack    = r_core_ack;
    assign core_data   = r_angle;
    assign core_region = r_region;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_ch        <= '0;
            r_op        <= '0;
            r_angle     <= '0;
            r_region    <= '0;
            r_pass      <= 1'b0;
            r_tmr       <= '0;
            r_res0      <= '0;
            r_res1      <= '0;
            r_ill       <= 1'b0;
            r_tmo       <= 1'b0;
            r_unf       <= 1'b0;
            r_ovf       <= 1'b0;
            r_core_beg  <= 1'b0;
            r_core_op   <= 1'b0;
            r_core_ack  <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_flags <= '0;
        end else begin
            r_core_beg <= 1'b0;
            r_core_ack <= 1'b0;
            // A DONE for a channel can only occur while its rsp_valid
            // is low, so the clear below never races the set in DONE.
            r_rsp_valid <= r_rsp_valid & ~rsp_ack;
            unique case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_ch     <= w_gnt;
                        r_op     <= w_gop;
                        r_angle  <= w_gang;
                        r_region <= w_greg;
                        r_pass   <= 1'b0;
                        r_res0   <= '0;
                        r_res1   <= '0;
                        r_tmo    <= 1'b0;
                        r_unf    <= 1'b0;
                        r_ovf    <= 1'b0;
                        if (w_gop == 2'b11) begin
                            r_ill   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_ill      <= 1'b0;
                            r_core_beg <= 1'b1;
                            // sine for op 01 and the first pass of op 10
                            r_core_op  <= (w_gop != 2'b00);
                            r_state    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_tmr   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_tmr <= w_tmr_nxt;
                    if (core_ready) begin
                        if (r_pass) begin
                            r_res1 <= core_result;
                        end else begin
                            r_res0 <= core_result;
                        end
                        r_ovf      <= r_ovf | core_ovf;
                        r_unf      <= r_unf | core_unf;
                        r_core_ack <= 1'b1;
                        r_state    <= S_ACK;
                    end else if (w_tmo_hit) begin
                        r_tmo      <= 1'b1;
                        r_core_ack <= 1'b1;
                        r_state    <= S_ABORT;
                    end
                end
                S_ACK: begin
                    if (r_op == 2'b10 && !r_pass) begin
                        r_pass     <= 1'b1;
                        r_core_beg <= 1'b1;
                        r_core_op  <= 1'b0;
                        r_state    <= S_ISSUE;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_ABORT: begin
                    r_res0  <= '0;
                    r_res1  <= '0;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_rsp_data[int'(r_ch)*2*W +: 2*W] <= {r_res1, r_res0};
                    r_rsp_flags[int'(r_ch)*4 +: 4] <=
                        {r_ill, r_tmo, r_unf, r_ovf};
                    r_rsp_valid[r_ch] <= 1'b1;
                    r_ptr <= (r_ch == CW'(N_CH - 1)) ? '0 : r_ch + 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
